// File: rtl/dma_periph_pkg.sv
// Shared types for the DMA peripheral endpoint.
// Channel FSM states and transfer direction encodings.
package dma_periph_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK,
    GAP
  } state_t;

  localparam logic DIR_DEV2MEM = 1'b0;
  localparam logic DIR_MEM2DEV = 1'b1;

endpackage

// File: rtl/dma_periph_fifo.sv
// Synchronous FIFO used for both tx and rx buffering.
// Push while full and pop while empty are dropped.
module dma_periph_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/dma_io_peripheral.sv
// Device-side endpoint of one 8237-style DMA channel.
// Handshakes DREQ/DACK and moves bytes between the bus and two FIFOs.
module dma_io_peripheral
  import dma_periph_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              enable,
  input  logic              dir,
  output logic              DREQ,
  input  logic              DACK,
  input  logic              IOR_N,
  input  logic              IOW_N,
  input  logic              EOP_N,
  input  logic [DATA_W-1:0] DB_IN,
  output logic [DATA_W-1:0] DB_OUT,
  output logic              DB_OE,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              tc_flag,
  input  logic              tc_clr,
  output logic              abort_err
);

  state_t            state;
  logic              dir_q;
  logic              strb_q;
  logic              eop_pend;
  logic              tc_q;
  logic              abort_q;
  logic [DATA_W-1:0] db_lat;

  logic              tx_full, tx_empty;
  logic              rx_full, rx_empty;
  logic [DATA_W-1:0] tx_head, rx_head;

  logic strb;
  logic in_ack;
  logic strb_end;
  logic abort_now;
  logic start;
  logic tc_set;

  assign in_ack    = (state == ACK);
  assign strb      = (dir_q == DIR_MEM2DEV) ? IOW_N : IOR_N;
  assign strb_end  = in_ack & ~strb_q & strb & DACK;
  assign abort_now = in_ack & ~strb_end & ~DACK;
  assign tc_set    = strb_end & (eop_pend | ~EOP_N);
  assign start     = enable &
                     ((dir == DIR_DEV2MEM) ? ~tx_empty : ~rx_full);

  assign DREQ      = (state == REQ);
  assign DB_OE     = in_ack & DACK & ~IOR_N & (dir_q == DIR_DEV2MEM);
  assign DB_OUT    = tx_empty ? '0 : tx_head;
  assign tx_ready  = ~tx_full;
  assign rx_valid  = ~rx_empty;
  assign rx_data   = rx_head;
  assign tc_flag   = tc_q;
  assign abort_err = abort_q;

  dma_periph_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (tx_valid),
    .pop   (strb_end & (dir_q == DIR_DEV2MEM)),
    .wdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head)
  );

  dma_periph_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (strb_end & (dir_q == DIR_MEM2DEV)),
    .pop   (rx_ready),
    .wdata (db_lat),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      dir_q    <= DIR_DEV2MEM;
      strb_q   <= 1'b1;
      eop_pend <= 1'b0;
      tc_q     <= 1'b0;
      abort_q  <= 1'b0;
      db_lat   <= '0;
    end else begin
      abort_q <= abort_now;
      // Outside ACK the strobe history reads as idle-high.
      strb_q  <= in_ack ? strb : 1'b1;
      if (in_ack && !strb)
        db_lat <= DB_IN;
      if (!in_ack || strb_end || abort_now)
        eop_pend <= 1'b0;
      else if (!EOP_N)
        eop_pend <= 1'b1;
      if (tc_set)
        tc_q <= 1'b1;
      else if (tc_clr)
        tc_q <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          dir_q <= dir;
          state <= REQ;
        end
        REQ: begin
          if (DACK)
            state <= ACK;
          else if (!enable)
            state <= IDLE;
        end
        ACK: begin
          if (strb_end)
            state <= GAP;
          else if (abort_now)
            state <= IDLE;
        end
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Directed bench for dma_io_peripheral.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_dma_io_peripheral;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       enable = 1'b0;
  logic       dir = 1'b0;
  logic       DREQ;
  logic       DACK = 1'b0;
  logic       IOR_N = 1'b1;
  logic       IOW_N = 1'b1;
  logic       EOP_N = 1'b1;
  logic [7:0] DB_IN = 8'h00;
  logic [7:0] DB_OUT;
  logic       DB_OE;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       tc_flag;
  logic       tc_clr = 1'b0;
  logic       abort_err;

  int errors = 0;
  int checks = 0;

  dma_io_peripheral #(.DATA_W(8), .DEPTH(8)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .enable    (enable),
    .dir       (dir),
    .DREQ      (DREQ),
    .DACK      (DACK),
    .IOR_N     (IOR_N),
    .IOW_N     (IOW_N),
    .EOP_N     (EOP_N),
    .DB_IN     (DB_IN),
    .DB_OUT    (DB_OUT),
    .DB_OE     (DB_OE),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .tc_flag   (tc_flag),
    .tc_clr    (tc_clr),
    .abort_err (abort_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (DREQ !== 1'b0) begin errors++; $display("FAIL rst_dreq got %b want 0", DREQ); end
    checks++; if (DB_OE !== 1'b0) begin errors++; $display("FAIL rst_oe got %b want 0", DB_OE); end
    checks++; if (DB_OUT !== 8'h00) begin errors++; $display("FAIL rst_dbout got %h want 00", DB_OUT); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_txrdy got %b want 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rxv got %b want 0", rx_valid); end
    checks++; if (tc_flag !== 1'b0) begin errors++; $display("FAIL rst_tc got %b want 0", tc_flag); end
    checks++; if (abort_err !== 1'b0) begin errors++; $display("FAIL rst_abort got %b want 0", abort_err); end
    tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    dir = 1'b0; enable = 1'b1; tx_valid = 1'b1; tx_data = 8'h11;
    tick();
    tx_valid = 1'b0;
    tick();
    checks++; if (DREQ !== 1'b1) begin errors++; $display("FAIL mid_dreq got %b want 1", DREQ); end
    DACK = 1'b1;
    tick();
    IOR_N = 1'b0;
    #1;
    checks++; if (DB_OE !== 1'b1) begin errors++; $display("FAIL mid_oe_pre got %b want 1", DB_OE); end
    RESET_N = 1'b0;
    #1;
    checks++; if (DB_OE !== 1'b0) begin errors++; $display("FAIL mid_oe got %b want 0", DB_OE); end
    checks++; if (DREQ !== 1'b0) begin errors++; $display("FAIL mid_dreq0 got %b want 0", DREQ); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_txrdy got %b want 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rxv got %b want 0", rx_valid); end
    checks++; if (DB_OUT !== 8'h00) begin errors++; $display("FAIL mid_dbout got %h want 00", DB_OUT); end
    checks++; if (abort_err !== 1'b0) begin errors++; $display("FAIL mid_abort got %b want 0", abort_err); end
    DACK = 1'b0; IOR_N = 1'b1; enable = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_dev2mem();
    dir = 1'b0; enable = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
    tick();
    checks++; if (DREQ !== 1'b0) begin errors++; $display("FAIL d2m_dreq_e1 got %b want 0", DREQ); end
    tx_data = 8'h5A;
    tick();
    tx_valid = 1'b0;
    checks++; if (DREQ !== 1'b1) begin errors++; $display("FAIL d2m_dreq_e2 got %b want 1", DREQ); end
    checks++; if (DB_OUT !== 8'hA5) begin errors++; $display("FAIL d2m_head got %h want a5", DB_OUT); end
    DACK = 1'b1;
    tick();
    checks++; if (DREQ !== 1'b0) begin errors++; $display("FAIL d2m_dreq_ack got %b want 0", DREQ); end
    checks++; if (DB_OE !== 1'b0) begin errors++; $display("FAIL d2m_oe_idle got %b want 0", DB_OE); end
    IOR_N = 1'b0;
    #1;
    checks++; if (DB_OE !== 1'b1) begin errors++; $display("FAIL d2m_oe got %b want 1", DB_OE); end
    checks++; if (DB_OUT !== 8'hA5) begin errors++; $display("FAIL d2m_dbout got %h want a5", DB_OUT); end
    tick();
    tick();
    IOR_N = 1'b1;
    tick();
    DACK = 1'b0;
    checks++; if (DB_OUT !== 8'h5A) begin errors++; $display("FAIL d2m_popped got %h want 5a", DB_OUT); end
    checks++; if (DREQ !== 1'b0) begin errors++; $display("FAIL d2m_gap got %b want 0", DREQ); end
    checks++; if (DB_OE !== 1'b0) begin errors++; $display("FAIL d2m_oe_gap got %b want 0", DB_OE); end
    tick();
    checks++; if (DREQ !== 1'b0) begin errors++; $display("FAIL d2m_idle got %b want 0", DREQ); end
    tick();
    checks++; if (DREQ !== 1'b1) begin errors++; $display("FAIL d2m_rereq got %b want 1", DREQ); end
    checks++; if (tc_flag !== 1'b0) begin errors++; $display("FAIL d2m_tc got %b want 0", tc_flag); end
    enable = 1'b0;
    tick();
    checks++; if (DREQ !== 1'b0) begin errors++; $display("FAIL d2m_withdraw got %b want 0", DREQ); end
  endtask

  task automatic test_abort();
    enable = 1'b1;
    tick();
    checks++; if (DREQ !== 1'b1) begin errors++; $display("FAIL ab_req got %b want 1", DREQ); end
    DACK = 1'b1;
    tick();
    DACK = 1'b0;
    tick();
    checks++; if (abort_err !== 1'b1) begin errors++; $display("FAIL ab_pulse got %b want 1", abort_err); end
    checks++; if (DB_OUT !== 8'h5A) begin errors++; $display("FAIL ab_keep got %h want 5a", DB_OUT); end
    checks++; if (DREQ !== 1'b0) begin errors++; $display("FAIL ab_dreq got %b want 0", DREQ); end
    tick();
    checks++; if (abort_err !== 1'b0) begin errors++; $display("FAIL ab_width got %b want 0", abort_err); end
    checks++; if (DREQ !== 1'b1) begin errors++; $display("FAIL ab_rereq got %b want 1", DREQ); end
    DACK = 1'b1;
    tick();
    IOR_N = 1'b0;
    tick();
    IOR_N = 1'b1;
    tick();
    DACK = 1'b0; enable = 1'b0;
    checks++; if (DB_OUT !== 8'h00) begin errors++; $display("FAIL ab_drain got %h want 00", DB_OUT); end
    tick();
    tick();
  endtask

  task automatic test_mem2dev();
    dir = 1'b1; enable = 1'b1;
    tick();
    checks++; if (DREQ !== 1'b1) begin errors++; $display("FAIL m2d_req got %b want 1", DREQ); end
    DACK = 1'b1;
    tick();
    IOW_N = 1'b0; IOR_N = 1'b0; DB_IN = 8'h3C;
    #1;
    checks++; if (DB_OE !== 1'b0) begin errors++; $display("FAIL m2d_oe got %b want 0", DB_OE); end
    tick();
    IOW_N = 1'b1; IOR_N = 1'b1; DB_IN = 8'hFF;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL m2d_early got %b want 0", rx_valid); end
    tick();
    DACK = 1'b0; enable = 1'b0;
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL m2d_rxv got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL m2d_data got %h want 3c", rx_data); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL m2d_pop got %b want 0", rx_valid); end
    tick();
  endtask

  task automatic test_rx_full();
    int waited;
    dir = 1'b1; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      waited = 0;
      while (DREQ !== 1'b1 && waited < 6) begin
        tick();
        waited++;
      end
      checks++; if (DREQ !== 1'b1) begin errors++; $display("FAIL full_wait%0d got %b want 1", i, DREQ); end
      DACK = 1'b1;
      tick();
      IOW_N = 1'b0; DB_IN = 8'h10 + 8'(i);
      tick();
      IOW_N = 1'b1;
      tick();
      DACK = 1'b0;
    end
    tick(); tick(); tick(); tick();
    checks++; if (DREQ !== 1'b0) begin errors++; $display("FAIL full_hold got %b want 0", DREQ); end
    checks++; if (rx_data !== 8'h10) begin errors++; $display("FAIL full_head got %h want 10", rx_data); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    checks++; if (DREQ !== 1'b1) begin errors++; $display("FAIL full_resume got %b want 1", DREQ); end
    enable = 1'b0;
    tick();
    for (int i = 1; i < 8; i++) begin
      checks++; if (rx_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL full_order%0d got %h want %h", i, rx_data, 8'h10 + 8'(i)); end
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", rx_valid); end
  endtask

  task automatic test_tc();
    dir = 1'b0; enable = 1'b1; tx_valid = 1'b1; tx_data = 8'h77;
    tick();
    tx_data = 8'h88;
    tick();
    tx_valid = 1'b0;
    DACK = 1'b1;
    tick();
    EOP_N = 1'b0; IOR_N = 1'b0;
    tick();
    EOP_N = 1'b1; IOR_N = 1'b1;
    checks++; if (tc_flag !== 1'b0) begin errors++; $display("FAIL tc_early got %b want 0", tc_flag); end
    tick();
    DACK = 1'b0;
    checks++; if (tc_flag !== 1'b1) begin errors++; $display("FAIL tc_set got %b want 1", tc_flag); end
    tick();
    tick();
    checks++; if (DREQ !== 1'b1) begin errors++; $display("FAIL tc_req2 got %b want 1", DREQ); end
    DACK = 1'b1;
    tick();
    IOR_N = 1'b0;
    tick();
    IOR_N = 1'b1; EOP_N = 1'b0; tc_clr = 1'b1;
    tick();
    tc_clr = 1'b0; EOP_N = 1'b1; DACK = 1'b0; enable = 1'b0;
    checks++; if (tc_flag !== 1'b1) begin errors++; $display("FAIL tc_setwins got %b want 1", tc_flag); end
    checks++; if (DB_OUT !== 8'h00) begin errors++; $display("FAIL tc_drain got %h want 00", DB_OUT); end
    tc_clr = 1'b1;
    tick();
    tc_clr = 1'b0;
    checks++; if (tc_flag !== 1'b0) begin errors++; $display("FAIL tc_clear got %b want 0", tc_flag); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_dev2mem();
    test_abort();
    test_mem2dev();
    test_rx_full();
    test_tc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
